fifo_rd_unpack: RTL and testbench

- Read-side consumer for the team's synchronous first-word-fall-through FIFO (full/empty/pop/dat interface).
- Pops IN_WIDTH-bit words from the FIFO and emits each as RATIO narrower OUT_WIDTH beats on a valid/ready stream.
- Sits between a wide FIFO and narrow peripheral datapaths (UART/SPI TX shifters, byte-lane streams).
- Sustains one beat per cycle, with no bubbles between words when the FIFO stays non-empty.

---
 rtl/fifo_rd_unpack_if.sv | 27 ++
 rtl/fifo_rd_unpack.sv | 105 ++++++++++
 tb/tb_fifo_rd_unpack.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_unpack_if.sv
// Bundle of the FIFO read port and the narrow valid/ready beat stream around
// fifo_rd_unpack. The master side is the unpacker; the slave side is FIFO + sink.
interface fifo_rd_unpack_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int CNT_W     = 2
);
    logic                 fifo_empty_i;
    logic [IN_WIDTH-1:0]  fifo_dat_i;
    logic                 fifo_pop_o;
    logic                 vld_o;
    logic                 rdy_i;
    logic [OUT_WIDTH-1:0] dat_o;
    logic                 last_o;
    logic [CNT_W-1:0]     beat_cnt_o;
    logic                 busy_o;

    modport master (
        input  fifo_empty_i, fifo_dat_i, rdy_i,
        output fifo_pop_o, vld_o, dat_o, last_o, beat_cnt_o, busy_o
    );

    modport slave (
        output fifo_empty_i, fifo_dat_i, rdy_i,
        input  fifo_pop_o, vld_o, dat_o, last_o, beat_cnt_o, busy_o
    );
endinterface

// File: rtl/fifo_rd_unpack.sv
// Pops wide words from a first-word-fall-through FIFO and streams each one out
// as RATIO narrow beats, back-to-back across words while the FIFO has data.
module fifo_rd_unpack #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = IN_WIDTH / OUT_WIDTH,
    parameter int CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    fifo_rd_unpack_if.master   bus
);

    generate
        if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO * OUT_WIDTH != IN_WIDTH || RATIO < 1) begin : g_bad_cfg
            $error("fifo_rd_unpack: IN_WIDTH must be a whole multiple of OUT_WIDTH");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state;
    logic [IN_WIDTH-1:0] sh;
    logic [IN_WIDTH-1:0] sh_shift;
    logic [CNT_W-1:0]    beat_cnt;
    logic                vld;
    logic                last;
    logic                hs;
    logic                load;

    assign vld  = (state == SEND);
    assign last = vld & (beat_cnt == LAST_CNT);
    assign hs   = vld & bus.rdy_i;

    // A new word is taken either from IDLE or on the final handshake of the
    // current word, which is what keeps the beat stream free of bubbles.
    assign load = ~flush_i & ~bus.fifo_empty_i & ((state == IDLE) | (hs & last));

    generate
        if (RATIO > 1) begin : g_shift
            if (LSB_FIRST) begin : g_lsb
                assign sh_shift = {OUT_WIDTH'(0), sh[IN_WIDTH-1:OUT_WIDTH]};
            end else begin : g_msb
                assign sh_shift = {sh[IN_WIDTH-OUT_WIDTH-1:0], OUT_WIDTH'(0)};
            end
        end else begin : g_noshift
            assign sh_shift = sh;
        end

        if (LSB_FIRST) begin : g_dat_lsb
            assign bus.dat_o = sh[OUT_WIDTH-1:0];
        end else begin : g_dat_msb
            assign bus.dat_o = sh[IN_WIDTH-1 -: OUT_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            sh       <= '0;
            beat_cnt <= '0;
        end else if (flush_i) begin
            // The beat shown this cycle may still be accepted; the rest is dropped.
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state    <= SEND;
                        sh       <= bus.fifo_dat_i;
                        beat_cnt <= '0;
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (last) begin
                            beat_cnt <= '0;
                            if (load) sh    <= bus.fifo_dat_i;
                            else      state <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                            sh       <= sh_shift;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.fifo_pop_o = load & ~rst_i;
    assign bus.vld_o      = vld;
    assign bus.busy_o     = vld;
    assign bus.last_o     = last;
    assign bus.beat_cnt_o = beat_cnt;

endmodule

// File: tb/tb_fifo_rd_unpack.sv
// Directed bench for fifo_rd_unpack: LSB-first 32->8, MSB-first 32->8 and an
// 8->8 pass-through instance, each fed by a small fall-through FIFO model.
module tb_fifo_rd_unpack;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fifo_rd_unpack_if #(.IN_WIDTH(32), .OUT_WIDTH(8), .CNT_W(2)) ia ();
    fifo_rd_unpack_if #(.IN_WIDTH(32), .OUT_WIDTH(8), .CNT_W(2)) ib ();
    fifo_rd_unpack_if #(.IN_WIDTH(8),  .OUT_WIDTH(8), .CNT_W(1)) ic ();

    fifo_rd_unpack #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(ia.master));
    fifo_rd_unpack #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(ib.master));
    fifo_rd_unpack #(.IN_WIDTH(8), .OUT_WIDTH(8), .LSB_FIRST(1'b1)) u_r1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(ic.master));

    // Fall-through FIFO models: head visible while non-empty, advance on pop.
    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];
    logic [7:0]  mem_c [16];
    logic [3:0]  wr_a = '0, rd_a = '0;
    logic [3:0]  wr_b = '0, rd_b = '0;
    logic [3:0]  wr_c = '0, rd_c = '0;
    int          pops_a = 0, pops_b = 0, pops_c = 0;

    assign ia.fifo_empty_i = (rd_a == wr_a);
    assign ia.fifo_dat_i   = mem_a[rd_a];
    assign ib.fifo_empty_i = (rd_b == wr_b);
    assign ib.fifo_dat_i   = mem_b[rd_b];
    assign ic.fifo_empty_i = (rd_c == wr_c);
    assign ic.fifo_dat_i   = mem_c[rd_c];

    always @(posedge clk) begin
        if (ia.fifo_pop_o) begin rd_a <= rd_a + 4'd1; pops_a <= pops_a + 1; end
        if (ib.fifo_pop_o) begin rd_b <= rd_b + 4'd1; pops_b <= pops_b + 1; end
        if (ic.fifo_pop_o) begin rd_c <= rd_c + 4'd1; pops_c <= pops_c + 1; end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // which: 0 = LSB-first, 1 = MSB-first, 2 = pass-through
    task automatic beat(input int which, input string tag, input int ev, input int ed,
                        input int el, input int ec, input int ep);
        logic [31:0] v, b, d, l, c, p;
        case (which)
            0: begin v = 32'(ia.vld_o); b = 32'(ia.busy_o); d = 32'(ia.dat_o);
                     l = 32'(ia.last_o); c = 32'(ia.beat_cnt_o); p = 32'(ia.fifo_pop_o); end
            1: begin v = 32'(ib.vld_o); b = 32'(ib.busy_o); d = 32'(ib.dat_o);
                     l = 32'(ib.last_o); c = 32'(ib.beat_cnt_o); p = 32'(ib.fifo_pop_o); end
            default: begin v = 32'(ic.vld_o); b = 32'(ic.busy_o); d = 32'(ic.dat_o);
                     l = 32'(ic.last_o); c = 32'(ic.beat_cnt_o); p = 32'(ic.fifo_pop_o); end
        endcase
        chk({tag, ".vld"},  v, ev);
        chk({tag, ".busy"}, b, ev);
        if (ed >= 0) chk({tag, ".dat"}, d, ed);
        chk({tag, ".last"}, l, el);
        chk({tag, ".cnt"},  c, ec);
        chk({tag, ".pop"},  p, ep);
    endtask

    logic [7:0] bp_exp [4];

    initial begin
        bp_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        ia.rdy_i = 1'b0;
        ib.rdy_i = 1'b0;
        ic.rdy_i = 1'b0;

        // Reset state on every instance
        tick; tick;
        beat(0, "rst_a", 0, 0, 0, 0, 0);
        beat(1, "rst_b", 0, 0, 0, 0, 0);
        beat(2, "rst_c", 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Single word, LSB first
        mem_a[wr_a] = 32'hDDCCBBAA; wr_a = wr_a + 4'd1;
        ia.rdy_i = 1'b1;
        #1 beat(0, "single_pop", 0, -1, 0, 0, 1);
        tick; beat(0, "single_b0", 1, 'hAA, 0, 0, 0);
        tick; beat(0, "single_b1", 1, 'hBB, 0, 1, 0);
        tick; beat(0, "single_b2", 1, 'hCC, 0, 2, 0);
        tick; beat(0, "single_b3", 1, 'hDD, 1, 3, 0);
        tick; beat(0, "single_end", 0, -1, 0, 0, 0);
        chk("single_pops", 32'(pops_a), 1);

        // Back-to-back words with no gap; second pop on beat 04
        mem_a[wr_a] = 32'h04030201; wr_a = wr_a + 4'd1;
        mem_a[wr_a] = 32'h08070605; wr_a = wr_a + 4'd1;
        #1 beat(0, "b2b_pop", 0, -1, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            tick;
            beat(0, $sformatf("b2b_b%0d", i), 1, i + 1, (i % 4 == 3) ? 1 : 0, i % 4, (i == 3) ? 1 : 0);
        end
        tick; beat(0, "b2b_end", 0, -1, 0, 0, 0);
        chk("b2b_pops", 32'(pops_a), 3);

        // Backpressure: rdy 1,0,0,1,... holds each beat stable
        mem_a[wr_a] = 32'h44332211; wr_a = wr_a + 4'd1;
        #1 beat(0, "bp_pop", 0, -1, 0, 0, 1);
        tick;
        for (int cyc = 0; cyc < 10; cyc++) begin
            int b;
            b = (cyc + 2) / 3;
            ia.rdy_i = (cyc % 3 == 0);
            #1 beat(0, $sformatf("bp_c%0d", cyc), 1, bp_exp[b], (b == 3) ? 1 : 0, b, 0);
            tick;
        end
        ia.rdy_i = 1'b1;
        #1 beat(0, "bp_end", 0, -1, 0, 0, 0);
        chk("bp_pops", 32'(pops_a), 4);

        // Flush after BB is accepted; next word restarts at beat 0
        mem_a[wr_a] = 32'hDDCCBBAA; wr_a = wr_a + 4'd1;
        mem_a[wr_a] = 32'h99887755; wr_a = wr_a + 4'd1;
        #1 beat(0, "fl_pop", 0, -1, 0, 0, 1);
        tick; beat(0, "fl_b0", 1, 'hAA, 0, 0, 0);
        tick; beat(0, "fl_b1", 1, 'hBB, 0, 1, 0);
        tick; flush = 1'b1;
        #1 beat(0, "fl_cyc", 1, 'hCC, 0, 2, 0);
        tick; flush = 1'b0;
        #1 beat(0, "fl_after", 0, -1, 0, 0, 1);
        tick; beat(0, "fl_nb0", 1, 'h55, 0, 0, 0);
        tick; tick;
        tick; beat(0, "fl_nb3", 1, 'h99, 1, 3, 0);
        tick; beat(0, "fl_end", 0, -1, 0, 0, 0);
        chk("fl_pops", 32'(pops_a), 6);

        // Reset mid-word discards the held word without re-popping
        mem_a[wr_a] = 32'hDDCCBBAA; wr_a = wr_a + 4'd1;
        #1 beat(0, "mr_pop", 0, -1, 0, 0, 1);
        tick; beat(0, "mr_b0", 1, 'hAA, 0, 0, 0);
        tick; rst = 1'b1;
        #1 chk("mr_pop_in_rst", 32'(ia.fifo_pop_o), 0);
        tick; beat(0, "mr_out", 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1 chk("mr_pops", 32'(pops_a), 7);
        tick; beat(0, "mr_idle", 0, 0, 0, 0, 0);

        // MSB first
        mem_b[wr_b] = 32'hDDCCBBAA; wr_b = wr_b + 4'd1;
        ib.rdy_i = 1'b1;
        #1 beat(1, "msb_pop", 0, -1, 0, 0, 1);
        tick; beat(1, "msb_b0", 1, 'hDD, 0, 0, 0);
        tick; beat(1, "msb_b1", 1, 'hCC, 0, 1, 0);
        tick; beat(1, "msb_b2", 1, 'hBB, 0, 2, 0);
        tick; beat(1, "msb_b3", 1, 'hAA, 1, 3, 0);
        tick; beat(1, "msb_end", 0, -1, 0, 0, 0);
        chk("msb_pops", 32'(pops_b), 1);

        // RATIO == 1 pass-through: every beat is last
        mem_c[wr_c] = 8'h11; wr_c = wr_c + 4'd1;
        mem_c[wr_c] = 8'h22; wr_c = wr_c + 4'd1;
        ic.rdy_i = 1'b1;
        #1 beat(2, "r1_pop", 0, -1, 0, 0, 1);
        tick; beat(2, "r1_b0", 1, 'h11, 1, 0, 1);
        tick; beat(2, "r1_b1", 1, 'h22, 1, 0, 0);
        tick; beat(2, "r1_end", 0, -1, 0, 0, 0);
        chk("r1_pops", 32'(pops_c), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
